// File: rtl/vsalu_seq_pkg.sv
// vsalu_seq_pkg: opcode encodings and FSM state encodings shared by the
// vsalu_seq top level, its divider and its interface.
package vsalu_seq_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_NAND = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_NOR  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_LAST = 4'hB;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_DIV  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/vsalu_seq_if.sv
// vsalu_seq_if: request/result handshake bundle for vsalu_seq.
//   master: operation source and result consumer (drives requests, out_ready)
//   slave : the ALU (drives in_ready, result, result_hi, flags, out_valid)
interface vsalu_seq_if
  import vsalu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [WIDTH-1:0]    opa;
  logic [WIDTH-1:0]    opb;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic [WIDTH-1:0]    result_hi;
  logic                flag_z;
  logic                flag_c;
  logic                flag_v;
  logic                flag_err;

  modport master (
    output in_valid, opcode, opa, opb, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  flag_z, flag_c, flag_v, flag_err
  );

  modport slave (
    input  in_valid, opcode, opa, opb, out_ready,
    output in_ready, out_valid, result, result_hi,
    output flag_z, flag_c, flag_v, flag_err
  );

endinterface

// File: rtl/vsalu_seq_div.sv
// vsalu_div: iterative restoring unsigned divider, one quotient bit per
// cycle, MSB first. A start pulse loads the operands; WIDTH iteration cycles
// follow, then o_done_c is high for one cycle while the results are valid.
//   i_start      : load operands and begin (divisor must be non-zero)
//   i_dividend   : dividend
//   i_divisor    : divisor
//   o_busy       : division in progress (including the done cycle)
//   o_done_c     : quotient/remainder valid this cycle
//   o_quotient   : quotient
//   o_remainder  : remainder
module vsalu_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    w_shift = (WIDTH + 1)'({r_rem, r_quot[WIDTH-1]});
    w_trial = w_shift - {1'b0, r_dvs};
    // Trial subtraction went negative exactly when the top bit is set.
    w_qbit  = ~w_trial[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'(WIDTH);
      r_busy <= 1'b1;
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_rem  <= w_qbit ? w_trial : w_shift;
        r_quot <= {r_quot[WIDTH-2:0], w_qbit};
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done_c    = r_busy && (r_cnt == '0);
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem[WIDTH-1:0];

endmodule

// File: rtl/vsalu_seq.sv
// vsalu_seq: registered ALU with valid/ready request and result handshakes.
// Single-cycle ops register their result on the accept edge; DIV with a
// non-zero divisor runs on vsalu_div and registers its result afterwards.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of vsalu_seq_if (request, result, flags)
module vsalu_seq
  import vsalu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  vsalu_seq_if.slave bus
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_div_go;
  logic               w_start_div;
  logic               w_load_alu;
  logic               w_load_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_alu_res;
  logic [WIDTH-1:0]   w_alu_hi;
  logic               w_alu_c;
  logic               w_alu_v;
  logic               w_alu_err;

  logic               w_div_busy;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_q;
  logic [WIDTH-1:0]   w_div_r;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_flag_z;
  logic               r_flag_c;
  logic               r_flag_v;
  logic               r_flag_err;

  // A result slot frees up in the same cycle the consumer takes it.
  assign w_in_ready = !w_div_busy &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  // Divide by zero bypasses the divider and completes like a single-cycle op.
  assign w_div_go   = (bus.opcode == OP_DIV) && (bus.opb != '0);

  vsalu_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start_div),
    .i_dividend  (bus.opa),
    .i_divisor   (bus.opb),
    .o_busy      (w_div_busy),
    .o_done_c    (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  // Single-cycle datapath and flags.
  always_comb begin
    w_sum     = {1'b0, bus.opa} + {1'b0, bus.opb};
    w_diff    = {1'b0, bus.opa} - {1'b0, bus.opb};
    w_prod    = (2*WIDTH)'(bus.opa) * (2*WIDTH)'(bus.opb);
    w_alu_res = '0;
    w_alu_hi  = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_err = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.opa[WIDTH-1] == bus.opb[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.opa[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (bus.opa[WIDTH-1] != bus.opb[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.opa[WIDTH-1]);
      end
      OP_MUL: begin
        w_alu_res = w_prod[WIDTH-1:0];
        w_alu_hi  = w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        // Only reaches the output registers when the divisor is zero.
        w_alu_res = '1;
        w_alu_hi  = bus.opa;
        w_alu_err = 1'b1;
      end
      OP_NOT:  w_alu_res = ~bus.opa;
      OP_AND:  w_alu_res = bus.opa & bus.opb;
      OP_OR:   w_alu_res = bus.opa | bus.opb;
      OP_NAND: w_alu_res = ~(bus.opa & bus.opb);
      OP_NOR:  w_alu_res = ~(bus.opa | bus.opb);
      OP_XOR:  w_alu_res = bus.opa ^ bus.opb;
      OP_SHL: begin
        w_alu_res = {bus.opa[WIDTH-2:0], 1'b0};
        w_alu_c   = bus.opa[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, bus.opa[WIDTH-1:1]};
        w_alu_c   = bus.opa[0];
      end
      default: w_alu_err = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and result-load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_div = 1'b0;
    w_load_alu  = 1'b0;
    w_load_div  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_div_go) begin
            w_state_nxt = S_DIV;
            w_start_div = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_load_alu  = 1'b1;
          end
        end else if ((r_state == S_DONE) && bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DIV: begin
        if (w_div_done) begin
          w_state_nxt = S_DONE;
          w_load_div  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers; they only move on an accept or a divide completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_flag_err  <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_load_alu) begin
        r_result    <= w_alu_res;
        r_result_hi <= w_alu_hi;
        r_flag_z    <= (w_alu_res == '0);
        r_flag_c    <= w_alu_c;
        r_flag_v    <= w_alu_v;
        r_flag_err  <= w_alu_err;
      end else if (w_load_div) begin
        r_result    <= w_div_q;
        r_result_hi <= w_div_r;
        r_flag_z    <= (w_div_q == '0);
        r_flag_c    <= 1'b0;
        r_flag_v    <= 1'b0;
        r_flag_err  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_v    = r_flag_v;
  assign bus.flag_err  = r_flag_err;

endmodule

// File: tb/tb_vsalu_seq.sv
// tb_vsalu_seq: directed self-checking bench for vsalu_seq at WIDTH=8 and
// WIDTH=16. Inputs are driven and outputs sampled 1 time unit after the
// rising clock edge.
module tb_vsalu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vsalu_seq_if #(.WIDTH(8))  if8 ();
  vsalu_seq_if #(.WIDTH(16)) if16 ();

  vsalu_seq #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  vsalu_seq #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the 8-bit bus, hold it through the accept edge,
  // then scramble the operands so late changes would show up as errors.
  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (if8.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (if8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send8_ready got=%b exp=1", if8.in_ready);
    end
    if8.opcode   = op;
    if8.opa      = a;
    if8.opb      = b;
    if8.in_valid = 1'b1;
    step();
    if8.in_valid = 1'b0;
    if8.opa      = 8'hFF;
    if8.opb      = 8'h01;
    if8.opcode   = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (if8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if8.out_valid); end
    checks++; if (if8.result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", if8.result); end
    checks++; if (if8.result_hi !== 8'h00) begin failures++; $display("FAIL reset_result_hi got=%h exp=00", if8.result_hi); end
    checks++; if ({if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err}); end
    rst_n = 1'b1;
    #1;
    checks++; if (if8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", if8.in_ready); end
    checks++; if (if16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready16 got=%b exp=1", if16.in_ready); end
  endtask

  task automatic test_add_sub();
    if8.out_ready = 1'b1;
    send8(4'h0, 8'h6A, 8'h3B);
    checks++; if (if8.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", if8.out_valid); end
    checks++; if (if8.result !== 8'hA5) begin failures++; $display("FAIL add_result got=%h exp=a5", if8.result); end
    checks++; if ({if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err} !== 4'b0010) begin failures++; $display("FAIL add_flags zcve got=%b exp=0010", {if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err}); end
    send8(4'h1, 8'h6A, 8'h3B);
    checks++; if (if8.result !== 8'h2F) begin failures++; $display("FAIL sub_result got=%h exp=2f", if8.result); end
    checks++; if ({if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err} !== 4'b0000) begin failures++; $display("FAIL sub_flags zcve got=%b exp=0000", {if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_err}); end
    // Borrow and signed overflow: 0x80 - 0x01 wraps to 0x7F, no borrow, V=1.
    send8(4'h1, 8'h80, 8'h01);
    checks++; if ({if8.result, if8.flag_c, if8.flag_v} !== {8'h7F, 1'b0, 1'b1}) begin failures++; $display("FAIL sub_ovf got=%h c=%b v=%b exp=7f c=0 v=1", if8.result, if8.flag_c, if8.flag_v); end
    send8(4'h1, 8'h01, 8'h02);
    checks++; if ({if8.result, if8.flag_c, if8.flag_v} !== {8'hFF, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h c=%b v=%b exp=ff c=1 v=0", if8.result, if8.flag_c, if8.flag_v); end
    step();
  endtask

  task automatic test_back_to_back();
    if8.out_ready = 1'b1;
    send8(4'h2, 8'h6A, 8'h3B);
    checks++; if ({if8.result_hi, if8.result} !== 16'h186E) begin failures++; $display("FAIL mul_product got=%h exp=186e", {if8.result_hi, if8.result}); end
    checks++; if (if8.out_valid !== 1'b1) begin failures++; $display("FAIL mul_out_valid got=%b exp=1", if8.out_valid); end
    send8(4'h5, 8'h6A, 8'h3B);
    checks++; if (if8.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid got=%b exp=1", if8.out_valid); end
    checks++; if ({if8.result_hi, if8.result} !== 16'h002A) begin failures++; $display("FAIL b2b_and got=%h exp=002a", {if8.result_hi, if8.result}); end
    step();
    checks++; if (if8.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain_out_valid got=%b exp=0", if8.out_valid); end
  endtask

  task automatic test_div();
    if8.out_ready = 1'b1;
    send8(4'h3, 8'h6A, 8'h3B);
    checks++; if (if8.in_ready !== 1'b0) begin failures++; $display("FAIL div_in_ready_k0 got=%b exp=0", if8.in_ready); end
    for (int k = 1; k <= 9; k++) begin
      if8.in_valid = 1'b1;
      step();
      if (k < 9) begin
        checks++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b0) begin failures++; $display("FAIL div_busy_k%0d out_valid=%b in_ready=%b exp=0 0", k, if8.out_valid, if8.in_ready); end
      end else begin
        checks++; if (if8.out_valid !== 1'b1) begin failures++; $display("FAIL div_latency got=%b exp=1 at cycle 9", if8.out_valid); end
      end
    end
    if8.in_valid = 1'b0;
    checks++; if ({if8.result, if8.result_hi} !== 16'h012F) begin failures++; $display("FAIL div_q_r got=%h exp=012f", {if8.result, if8.result_hi}); end
    checks++; if (if8.flag_err !== 1'b0) begin failures++; $display("FAIL div_err got=%b exp=0", if8.flag_err); end
    send8(4'h3, 8'h6A, 8'h00);
    checks++; if (if8.out_valid !== 1'b1) begin failures++; $display("FAIL div0_latency got=%b exp=1", if8.out_valid); end
    checks++; if ({if8.result, if8.result_hi, if8.flag_err, if8.flag_z} !== {8'hFF, 8'h6A, 1'b1, 1'b0}) begin failures++; $display("FAIL div0_result got=%h hi=%h err=%b z=%b exp=ff 6a 1 0", if8.result, if8.result_hi, if8.flag_err, if8.flag_z); end
    step();
  endtask

  task automatic test_backpressure();
    if8.out_ready = 1'b0;
    send8(4'h2, 8'h6A, 8'h3B);
    checks++; if (if8.out_valid !== 1'b1 || if8.result !== 8'h6E) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/6e", if8.out_valid, if8.result); end
    if8.opcode   = 4'h0;
    if8.opa      = 8'h01;
    if8.opb      = 8'h01;
    if8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if ({if8.out_valid, if8.in_ready, if8.result_hi, if8.result} !== {1'b1, 1'b0, 16'h186E}) begin failures++; $display("FAIL bp_hold_%0d got v=%b rdy=%b %h%h exp v=1 rdy=0 186e", k, if8.out_valid, if8.in_ready, if8.result_hi, if8.result); end
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    #1;
    checks++; if (if8.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", if8.in_ready); end
    step();
    checks++; if (if8.out_valid !== 1'b0) begin failures++; $display("FAIL bp_complete got=%b exp=0", if8.out_valid); end
  endtask

  task automatic test_illegal_shift();
    if8.out_ready = 1'b1;
    send8(4'hD, 8'h6A, 8'h3B);
    checks++; if ({if8.result, if8.result_hi, if8.flag_z, if8.flag_err} !== {16'h0000, 1'b1, 1'b1}) begin failures++; $display("FAIL illegal got=%h hi=%h z=%b err=%b exp=00 00 1 1", if8.result, if8.result_hi, if8.flag_z, if8.flag_err); end
    send8(4'hA, 8'h80, 8'h00);
    checks++; if ({if8.result, if8.flag_c, if8.flag_z, if8.flag_err} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin failures++; $display("FAIL shl got=%h c=%b z=%b err=%b exp=00 1 1 0", if8.result, if8.flag_c, if8.flag_z, if8.flag_err); end
    send8(4'hB, 8'h01, 8'h00);
    checks++; if ({if8.result, if8.flag_c} !== {8'h00, 1'b1}) begin failures++; $display("FAIL shr got=%h c=%b exp=00 1", if8.result, if8.flag_c); end
    send8(4'h9, 8'h6A, 8'h3B);
    checks++; if (if8.result !== 8'h51) begin failures++; $display("FAIL xor got=%h exp=51", if8.result); end
    step();
  endtask

  task automatic test_reset_mid_div();
    if8.out_ready = 1'b1;
    send8(4'h0, 8'h6A, 8'h3B);
    send8(4'h3, 8'h6A, 8'h3B);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({if8.out_valid, if8.result, if8.result_hi, if8.flag_v} !== {1'b0, 16'h0000, 1'b0}) begin failures++; $display("FAIL middiv_reset got v=%b %h %h ovf=%b exp 0 00 00 0", if8.out_valid, if8.result, if8.result_hi, if8.flag_v); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (if8.out_valid !== 1'b0) begin failures++; $display("FAIL middiv_no_stale got=%b exp=0", if8.out_valid); end
    send8(4'h0, 8'h6A, 8'h3B);
    checks++; if ({if8.out_valid, if8.result} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL middiv_fresh_add got=%b/%h exp=1/a5", if8.out_valid, if8.result); end
    step();
  endtask

  task automatic test_width16();
    int n;
    if16.out_ready = 1'b1;
    if16.opcode    = 4'h3;
    if16.opa       = 16'hFFFF;
    if16.opb       = 16'h0003;
    if16.in_valid  = 1'b1;
    step();
    if16.in_valid  = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin failures++; $display("FAIL w16_reset got v=%b rdy=%b exp 0 1", if16.out_valid, if16.in_ready); end
    step();
    rst_n = 1'b1;
    step();
    if16.in_valid = 1'b1;
    step();
    if16.in_valid = 1'b0;
    if16.opa      = 16'h0000;
    n = 0;
    while (if16.out_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++; if (n !== 17) begin failures++; $display("FAIL w16_div_latency got=%0d exp=17", n); end
    checks++; if ({if16.result, if16.result_hi} !== 32'h5555_0000) begin failures++; $display("FAIL w16_div got=%h/%h exp=5555/0000", if16.result, if16.result_hi); end
    checks++; if ({if16.flag_z, if16.flag_err} !== 2'b00) begin failures++; $display("FAIL w16_flags got=%b exp=00", {if16.flag_z, if16.flag_err}); end
    step();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    if8.in_valid   = 1'b0;
    if8.opcode     = 4'h0;
    if8.opa        = 8'h00;
    if8.opb        = 8'h00;
    if8.out_ready  = 1'b0;
    if16.in_valid  = 1'b0;
    if16.opcode    = 4'h0;
    if16.opa       = 16'h0000;
    if16.opb       = 16'h0000;
    if16.out_ready = 1'b0;
    repeat (3) step();
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_div();
    test_backpressure();
    test_illegal_shift();
    test_reset_mid_div();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
